// File: rtl/mlt3_pkg.sv
// mlt3_pkg: shared state encoding, CRC step and default constants for the MLT-3 transmit sequencer
// Contents: tx_state_t, CRC8_POLY, RUN_MAX_DEF, PREAMBLE_LEN_DEF, crc8_step()
package mlt3_pkg;
    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, STUFF, CRC, EOF} tx_state_t;
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam int RUN_MAX_DEF = 6;
    localparam int PREAMBLE_LEN_DEF = 8;
    // one bit of a non-reflected CRC-8, MSB-first register
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/mlt3_tx_ctrl_stuffer.sv
// mlt3_stuffer: run-length tracker that requests a stuff bit after RUN_MAX-1 identical line bits
// Ports: clk, rst (async, active-high), en (tracking active), clr (restart run),
//        line_bit (bit in the current slot), slot_start (first cycle of slot),
//        stuff_req (current slot completes a run of RUN_MAX-1)
module mlt3_stuffer import mlt3_pkg::*; #(
    parameter int RUN_MAX = RUN_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic line_bit,
    input  logic slot_start,
    output logic stuff_req
);
    localparam int RW = $clog2(RUN_MAX + 1);
    localparam logic [RW-1:0] RUN_SAT = RW'(RUN_MAX);
    localparam logic [RW-1:0] RUN_LIM = RW'(RUN_MAX - 1);
    logic [RW-1:0] run, run_nxt;
    logic last;
    assign run_nxt = (run != '0 && line_bit == last) ? ((run == RUN_SAT) ? RUN_SAT : run + 1'b1) : RW'(1);
    // the register absorbs the slot's bit on its first cycle, so later cycles of the slot read it directly
    assign stuff_req = en && ((slot_start ? run_nxt : run) >= RUN_LIM);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run  <= '0;
            last <= 1'b0;
        end else if (clr) begin
            run  <= '0;
        end else if (en && slot_start) begin
            run  <= run_nxt;
            last <= line_bit;
        end
    end
endmodule

// File: rtl/mlt3_tx_ctrl.sv
// mlt3_tx_ctrl: frames bytes as preamble, bit-stuffed payload and EOF delimiter for the MLT-3 encoder
// Ports: clk, rst (async, active-high), s_data/s_valid/s_last/s_ready (byte input handshake),
//        enc_b1t (line bit, high only on slot_start), slot_start (first cycle of each bit slot),
//        busy (frame in progress), frame_done (last cycle of EOF), underrun (payload starved)
// Build option: MLT3_TX_CRC_EN appends a CRC-8 (poly 0x07) after the payload.
module mlt3_tx_ctrl import mlt3_pkg::*; #(
    parameter int DATA_W       = 8,
    parameter int RUN_MAX      = RUN_MAX_DEF,
    parameter int PREAMBLE_LEN = PREAMBLE_LEN_DEF,
    parameter int BAUD_DIV     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              enc_b1t,
    output logic              slot_start,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int CW = $clog2(PREAMBLE_LEN + DATA_W + RUN_MAX + 16);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(PREAMBLE_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] DATA_END  = CW'(DATA_W);
    localparam logic [CW-1:0] EOF_LAST  = CW'(RUN_MAX - 1);
`ifdef MLT3_TX_CRC_EN
    localparam logic [CW-1:0] CRC_LAST  = CW'(7);
    localparam logic [CW-1:0] CRC_END   = CW'(8);
    localparam tx_state_t TAIL = CRC;
    logic [7:0] crc;
    logic in_crc;
`else
    localparam tx_state_t TAIL = EOF;
`endif
    tx_state_t state, state_n;
    logic [BW-1:0] baud;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] sh, hold_data;
    logic hold_valid, hold_last, cur_last, prev, bit_cur, slot_end, stuff_req;
    logic accept, load, byte_end, cnt_clr;
    assign busy       = state != IDLE;
    assign s_ready    = !hold_valid;
    assign accept     = s_valid && s_ready;
    assign slot_start = busy && baud == '0;
    assign slot_end   = busy && baud == BAUD_LAST;
    assign enc_b1t    = bit_cur && slot_start;
    mlt3_stuffer #(.RUN_MAX(RUN_MAX)) u_stuffer (
        .clk       (clk),
        .rst       (rst),
        .en        (state == DATA || state == STUFF || state == CRC),
        .clr       (state == PREAMBLE),
        .line_bit  (bit_cur),
        .slot_start(slot_start),
        .stuff_req (stuff_req)
    );
    always_comb begin
        bit_cur = 1'b0;
        case (state)
            PREAMBLE: bit_cur = !cnt[0];
            DATA:     bit_cur = sh[0];
            STUFF:    bit_cur = !prev;
`ifdef MLT3_TX_CRC_EN
            CRC:      bit_cur = crc[7];
`endif
            EOF:      bit_cur = 1'b1;
            default:  bit_cur = 1'b0;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n    = state;
        load       = 1'b0;
        byte_end   = 1'b0;
        underrun   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE:     state_n = (hold_valid || accept) ? PREAMBLE : IDLE;
            PREAMBLE: if (slot_end && cnt == PRE_LAST) begin
                state_n = DATA;
                load    = 1'b1;
            end
            DATA:     if (slot_end) begin
                if (stuff_req) state_n = STUFF;
                else byte_end = cnt == DATA_LAST;
            end
            // cnt already counts the bit that triggered the stuff, so it tells whether the byte is exhausted
            STUFF:    if (slot_end) begin
`ifdef MLT3_TX_CRC_EN
                if (in_crc) state_n = (cnt == CRC_END) ? EOF : CRC;
                else
`endif
                if (cnt == DATA_END) byte_end = 1'b1;
                else state_n = DATA;
            end
`ifdef MLT3_TX_CRC_EN
            CRC:      if (slot_end) state_n = stuff_req ? STUFF : (cnt == CRC_LAST) ? EOF : CRC;
`endif
            EOF:      if (slot_end && cnt == EOF_LAST) begin
                state_n    = IDLE;
                frame_done = 1'b1;
            end
            default:  state_n = IDLE;
        endcase
        if (byte_end) begin
            load     = !cur_last && hold_valid;
            underrun = !cur_last && !hold_valid;
            state_n  = load ? DATA : TAIL;
        end
        cnt_clr = load || byte_end || frame_done || (state_n == EOF && state != EOF);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud       <= '0;
            cnt        <= '0;
            sh         <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            hold_last  <= 1'b0;
            cur_last   <= 1'b0;
            prev       <= 1'b0;
`ifdef MLT3_TX_CRC_EN
            crc        <= '0;
            in_crc     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                hold_data <= s_data;
                hold_last <= s_last;
            end
            hold_valid <= accept || (hold_valid && !load);
            baud <= (!busy || baud == BAUD_LAST) ? '0 : baud + 1'b1;
            if (cnt_clr) cnt <= '0;
            else if (slot_end && state != STUFF) cnt <= cnt + 1'b1;
            if (load) begin
                sh       <= hold_data;
                cur_last <= hold_last;
            end else if (state == DATA && slot_end) begin
                sh <= sh >> 1;
            end
            if (slot_end) prev <= bit_cur;
`ifdef MLT3_TX_CRC_EN
            if (state == IDLE) crc <= '0;
            else if (state == DATA && slot_end) crc <= crc8_step(crc, sh[0]);
            else if (state == CRC && slot_end) crc <= {crc[6:0], 1'b0};
            in_crc <= (state == CRC) || (in_crc && state != IDLE);
`endif
        end
    end
endmodule

// File: tb/tb_mlt3_tx_ctrl.sv
// tb_mlt3_tx_ctrl: scoreboard bench; expected line bits come from a frame-level stuffing model
module tb_mlt3_tx_ctrl;
    localparam int BD = 4;
    localparam int RUN_MAX = 6;
    localparam int PRE = 8;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] s_data = '0;
    logic s_valid = 1'b0, s_last = 1'b0;
    logic s_ready, enc_b1t, slot_start, busy, frame_done, underrun;
    int checks = 0, errors = 0;
    bit exp_bits[$];
    int exp_len[$];
    int exp_und[$];
    logic [7:0] fr[$];
    int nslot = 0, nund = 0, fcyc = 0, since = 0;

    mlt3_tx_ctrl #(.DATA_W(8), .RUN_MAX(RUN_MAX), .PREAMBLE_LEN(PRE), .BAUD_DIV(BD)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .enc_b1t(enc_b1t), .slot_start(slot_start), .busy(busy),
        .frame_done(frame_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // expected line: preamble, payload LSB first (plus CRC) with stuffing, RUN_MAX ones
    task automatic push_frame(input bit und);
        bit tx[$];
        int run, n;
        bit lastb;
`ifdef MLT3_TX_CRC_EN
        logic [7:0] c;
`endif
        n = 0;
        run = 0;
        lastb = 1'b0;
        for (int i = 0; i < PRE; i++) begin
            exp_bits.push_back(i % 2 == 0);
            n++;
        end
        foreach (fr[k]) for (int j = 0; j < 8; j++) tx.push_back(fr[k][j]);
`ifdef MLT3_TX_CRC_EN
        c = 8'h00;
        foreach (tx[i]) c = {c[6:0], 1'b0} ^ ((c[7] ^ tx[i]) ? 8'h07 : 8'h00);
        for (int i = 7; i >= 0; i--) tx.push_back(c[i]);
`endif
        foreach (tx[i]) begin
            exp_bits.push_back(tx[i]);
            n++;
            run = (run > 0 && tx[i] == lastb) ? run + 1 : 1;
            lastb = tx[i];
            if (run == RUN_MAX - 1) begin
                exp_bits.push_back(!lastb);
                n++;
                lastb = !lastb;
                run = 1;
            end
        end
        repeat (RUN_MAX) begin
            exp_bits.push_back(1'b1);
            n++;
        end
        exp_len.push_back(n);
        exp_und.push_back(int'(und));
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        s_data = d;
        s_last = l;
        s_valid = 1'b1;
        while (!s_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("send_timeout", 1, 0);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || exp_bits.size() != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("idle_timeout", 1, 0);
    endtask

    task automatic frame(input bit und);
        push_frame(und);
        foreach (fr[k]) begin
            send(fr[k], !und && k == fr.size() - 1);
            if (k == 0) begin
                chk("busy_after_accept", busy, 1);
                chk("ready_low_after_accept", s_ready, 0);
            end
        end
        if (und) wait_idle();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            nslot = 0;
            nund = 0;
            fcyc = 0;
            since = 0;
        end else if (!busy) begin
            chk("idle_quiet", {slot_start, enc_b1t, frame_done, underrun}, 0);
            since = 0;
        end else begin
            since++;
            if (slot_start) begin
                if (nslot > 0) chk("slot_period", since, BD);
                since = 0;
                if (exp_bits.size() == 0) chk("extra_bit", 1, 0);
                else chk("line_bit", enc_b1t, exp_bits.pop_front());
                nslot++;
            end else begin
                chk("off_slot_b1t", enc_b1t, 0);
            end
            if (underrun) nund++;
            if (frame_done) begin
                if (exp_len.size() == 0) chk("extra_frame", 1, 0);
                else begin
                    chk("frame_slots", nslot, exp_len.pop_front());
                    chk("underrun_count", nund, exp_und.pop_front());
                end
                chk("frame_cycles", fcyc, nslot * BD - 1);
                nslot = 0;
                nund = 0;
                fcyc = -1;
            end
            fcyc++;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", s_ready, 1);
        chk("rst_outputs", {enc_b1t, slot_start, busy, frame_done, underrun}, 0);
        rst = 1'b0;
        @(negedge clk);
        fr = '{8'hA5};
        frame(0);
        wait_idle();
        // abort a frame in the middle of its payload
        fr = '{8'hC3};
        frame(0);
        repeat (12 * BD) @(negedge clk);
        chk("busy_before_abort", busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("abort_b1t", enc_b1t, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", s_ready, 1);
        chk("abort_slot_start", slot_start, 0);
        exp_bits.delete();
        exp_len.delete();
        exp_und.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        fr = '{8'hFF};
        frame(0);
        fr = '{8'h00, 8'hF0};
        frame(0);
        fr = '{8'h3C};
        frame(1);
        fr = '{8'h01};
        frame(0);
        for (int f = 0; f < 25; f++) begin
            int n;
            n = $urandom_range(1, 4);
            fr = {};
            for (int b = 0; b < n; b++) begin
                int r;
                r = $urandom_range(0, 3);
                fr.push_back(r == 0 ? 8'h00 : r == 1 ? 8'hFF : 8'($urandom));
            end
            frame($urandom_range(0, 4) == 0);
        end
        wait_idle();
        chk("leftover_bits", exp_bits.size(), 0);
        chk("leftover_frames", exp_len.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
